// File: rtl/iir_sched.sv
// ---------------------------------------------------------------------------
// iir_sched
// Time-multiplexed first-order IIR engine for the stereo de-emphasis stage.
// Left (channel 0) and right (channel 1) samples are arbitrated round-robin
// onto one shared signed multiplier. Each sample takes three products:
//     y[n] = deq(B0*x[n]) + deq(B1*x[n-1]) - deq(A1*y[n-1])
// deq() is an arithmetic right shift by FRAC_BITS that keeps the low
// DATA_WIDTH bits. All sums wrap, with no saturation.
//
// Optional feature macro: IIR_SCHED_COEF_WR_EN
//   When defined, this adds run-time writable coefficient registers and the
//   coef_* ports. When undefined, the coefficients are the constant parameters.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   din         in   din[c] = input sample for channel c
//   din_valid   in   per-channel sample valid
//   din_ready   out  per-channel accept (one-hot or zero); combinational
//   dout        out  filtered sample (registered)
//   dout_ch     out  channel of dout (registered)
//   dout_valid  out  result valid (registered)
//   dout_ready  in   downstream accept
//   coef_wr     in   coefficient write strobe        (IIR_SCHED_COEF_WR_EN)
//   coef_addr   in   0=B0, 1=B1, 2=A1, 3=ignored     (IIR_SCHED_COEF_WR_EN)
//   coef_wdata  in   coefficient write data          (IIR_SCHED_COEF_WR_EN)
// ---------------------------------------------------------------------------
module iir_sched #(
    parameter int                            DATA_WIDTH = 32,
    parameter int                            FRAC_BITS  = 10,
    parameter logic signed [DATA_WIDTH-1:0]  B0         = 32'sd179,
    parameter logic signed [DATA_WIDTH-1:0]  B1         = 32'sd179,
    parameter logic signed [DATA_WIDTH-1:0]  A1         = -32'sd666
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [1:0][DATA_WIDTH-1:0]   din,
    input  logic [1:0]                   din_valid,
    output logic [1:0]                   din_ready,
    output logic [DATA_WIDTH-1:0]        dout,
    output logic                         dout_ch,
    output logic                         dout_valid,
    input  logic                         dout_ready
`ifdef IIR_SCHED_COEF_WR_EN
    ,
    input  logic                         coef_wr,
    input  logic [1:0]                   coef_addr,
    input  logic [DATA_WIDTH-1:0]        coef_wdata
`endif
);

    localparam int PW = 2 * DATA_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MB0  = 3'd1,
        ST_MB1  = 3'd2,
        ST_MA1  = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

    // Dequantize a full-width product. The shift floors toward minus
    // infinity, and the truncation to DATA_WIDTH gives the wrap behaviour.
    function automatic logic signed [DATA_WIDTH-1:0] deq(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] shifted;
        shifted = p >>> FRAC_BITS;
        return shifted[DATA_WIDTH-1:0];
    endfunction

    // FSM and arbitration
    state_t                         state_r;
    state_t                         next_state_s;
    logic                           ptr_r;
    logic                           grant_s;
    logic                           any_valid_s;
    logic                           accept_s;
    logic                           out_done_s;
    logic [1:0]                     din_ready_s;

    // Sample in flight
    logic                           ch_r;
    logic signed [DATA_WIDTH-1:0]   x_r;
    logic signed [DATA_WIDTH-1:0]   acc_r;
    logic signed [DATA_WIDTH-1:0]   b0_snap_r;
    logic signed [DATA_WIDTH-1:0]   b1_snap_r;
    logic signed [DATA_WIDTH-1:0]   a1_snap_r;

    // Per-channel filter history
    logic signed [DATA_WIDTH-1:0]   x_prev_r [2];
    logic signed [DATA_WIDTH-1:0]   y_prev_r [2];

    // Live coefficients (constant or writable)
    logic signed [DATA_WIDTH-1:0]   coef_b0_s;
    logic signed [DATA_WIDTH-1:0]   coef_b1_s;
    logic signed [DATA_WIDTH-1:0]   coef_a1_s;

    // Shared multiplier
    logic signed [DATA_WIDTH-1:0]   mul_coef_s;
    logic signed [DATA_WIDTH-1:0]   mul_data_s;
    logic signed [PW-1:0]           prod_s;
    logic signed [DATA_WIDTH-1:0]   term_s;
    logic signed [DATA_WIDTH-1:0]   final_s;

    // Registered outputs
    logic [DATA_WIDTH-1:0]          dout_r;
    logic                           dout_ch_r;
    logic                           dout_valid_r;

`ifdef IIR_SCHED_COEF_WR_EN
    logic signed [DATA_WIDTH-1:0]   coef_b0_r;
    logic signed [DATA_WIDTH-1:0]   coef_b1_r;
    logic signed [DATA_WIDTH-1:0]   coef_a1_r;

    // Writable coefficient bank. A write becomes visible on the next cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            coef_b0_r <= B0;
            coef_b1_r <= B1;
            coef_a1_r <= A1;
        end else if (coef_wr) begin
            case (coef_addr)
                2'd0:    coef_b0_r <= coef_wdata;
                2'd1:    coef_b1_r <= coef_wdata;
                2'd2:    coef_a1_r <= coef_wdata;
                default: ;
            endcase
        end
    end

    assign coef_b0_s = coef_b0_r;
    assign coef_b1_s = coef_b1_r;
    assign coef_a1_s = coef_a1_r;
`else
    assign coef_b0_s = B0;
    assign coef_b1_s = B1;
    assign coef_a1_s = A1;
`endif

    // Round-robin grant: the pointer breaks ties, and a lone requester always wins.
    always_comb begin
        any_valid_s = |din_valid;
        grant_s     = 1'b0;
        if (din_valid == 2'b11) begin
            grant_s = ptr_r;
        end else if (din_valid[1]) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_valid_s) begin
                    next_state_s = ST_MB0;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_MB0:  next_state_s = ST_MB1;
            ST_MB1:  next_state_s = ST_MA1;
            ST_MA1:  next_state_s = ST_OUT;
            ST_OUT: begin
                if (dout_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_OUT;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM outputs: the accept handshake, multiplier operand selection and the output handshake
    always_comb begin
        din_ready_s = 2'b00;
        accept_s    = 1'b0;
        out_done_s  = 1'b0;
        mul_coef_s  = {DATA_WIDTH{1'b0}};
        mul_data_s  = {DATA_WIDTH{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (any_valid_s) begin
                    accept_s             = 1'b1;
                    din_ready_s[grant_s] = 1'b1;
                end else begin
                    accept_s = 1'b0;
                end
            end
            ST_MB0: begin
                mul_coef_s = b0_snap_r;
                mul_data_s = x_r;
            end
            ST_MB1: begin
                mul_coef_s = b1_snap_r;
                mul_data_s = x_prev_r[ch_r];
            end
            ST_MA1: begin
                mul_coef_s = a1_snap_r;
                mul_data_s = y_prev_r[ch_r];
            end
            ST_OUT: begin
                out_done_s = dout_ready;
            end
            default: ;
        endcase
    end

    // Shared multiplier. The operands are sign-extended so that the full-width product is exact.
    always_comb begin
        prod_s  = PW'(mul_coef_s) * PW'(mul_data_s);
        term_s  = deq(prod_s);
        final_s = acc_r - term_s;
    end

    // Round-robin pointer. It moves to the other channel after every grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_r <= 1'b0;
        end else if (accept_s) begin
            ptr_r <= ~grant_s;
        end
    end

    // Accept: latch the sample, its channel and a coefficient snapshot for the whole computation
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ch_r      <= 1'b0;
            x_r       <= {DATA_WIDTH{1'b0}};
            b0_snap_r <= {DATA_WIDTH{1'b0}};
            b1_snap_r <= {DATA_WIDTH{1'b0}};
            a1_snap_r <= {DATA_WIDTH{1'b0}};
        end else if (accept_s) begin
            ch_r      <= grant_s;
            x_r       <= din[grant_s];
            b0_snap_r <= coef_b0_s;
            b1_snap_r <= coef_b1_s;
            a1_snap_r <= coef_a1_s;
        end
    end

    // Accumulator sequencing plus the registered result, loaded as the last product completes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_r        <= {DATA_WIDTH{1'b0}};
            dout_r       <= {DATA_WIDTH{1'b0}};
            dout_ch_r    <= 1'b0;
            dout_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_MB0: acc_r <= term_s;
                ST_MB1: acc_r <= acc_r + term_s;
                ST_MA1: begin
                    acc_r        <= final_s;
                    dout_r       <= final_s;
                    dout_ch_r    <= ch_r;
                    dout_valid_r <= 1'b1;
                end
                ST_OUT: begin
                    if (dout_ready) begin
                        dout_valid_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // History update. Only a sample that completes its output handshake commits to its own channel.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_prev_r[0] <= {DATA_WIDTH{1'b0}};
            x_prev_r[1] <= {DATA_WIDTH{1'b0}};
            y_prev_r[0] <= {DATA_WIDTH{1'b0}};
            y_prev_r[1] <= {DATA_WIDTH{1'b0}};
        end else if (out_done_s) begin
            x_prev_r[ch_r] <= x_r;
            y_prev_r[ch_r] <= acc_r;
        end
    end

    // din_ready is forced low while reset is high, so every output reads 0 during reset.
    assign din_ready  = din_ready_s & {2{~reset}};
    assign dout       = dout_r;
    assign dout_ch    = dout_ch_r;
    assign dout_valid = dout_valid_r;

endmodule

// File: tb/tb_iir_sched.sv
// ---------------------------------------------------------------------------
// tb_iir_sched
// Directed self-checking bench for iir_sched. Inputs are driven on the
// falling edge, and outputs are sampled on the falling edge (or #1 after it).
// ---------------------------------------------------------------------------
module tb_iir_sched;

    logic              clock;
    logic              reset;
    logic [1:0][31:0]  din;
    logic [1:0]        din_valid;
    logic [1:0]        din_ready;
    logic [31:0]       dout;
    logic              dout_ch;
    logic              dout_valid;
    logic              dout_ready;
`ifdef IIR_SCHED_COEF_WR_EN
    logic              coef_wr;
    logic [1:0]        coef_addr;
    logic [31:0]       coef_wdata;
`endif

    int n_tests;
    int n_fail;
    int lat;
    int g[$];
    logic both_hi;

    iir_sched dut (
        .clock      (clock),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_ch    (dout_ch),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
`ifdef IIR_SCHED_COEF_WR_EN
        ,
        .coef_wr    (coef_wr),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offer one sample on channel c at the current falling edge, with dout_ready held high.
    // Check the accept, the 4-cycle latency and the result, then return in IDLE.
    task automatic send(input int c, input logic [31:0] x, input logic [31:0] exp, input string tag);
        logic [1:0] want;
        int l;
        want    = 2'b00;
        want[c] = 1'b1;
        din[c]    = x;
        din_valid = want;
        #1;
        chk({tag, "_rdy"}, din_ready, want);
        @(negedge clock);
        din_valid = 2'b00;
        l = 1;
        while (dout_valid !== 1'b1 && l < 12) begin
            @(negedge clock);
            l++;
        end
        chk({tag, "_lat"}, l, 4);
        chk({tag, "_dout"}, dout, exp);
        chk({tag, "_ch"}, dout_ch, c);
        @(negedge clock);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b1;
        din        = '0;
        din_valid  = 2'b00;
        dout_ready = 1'b1;
`ifdef IIR_SCHED_COEF_WR_EN
        coef_wr    = 1'b0;
        coef_addr  = 2'd0;
        coef_wdata = 32'd0;
`endif
        // Reset state
        #1;
        chk("rst_rdy", din_ready, 2'b00);
        chk("rst_dout", dout, 32'd0);
        chk("rst_ch", dout_ch, 1'b0);
        chk("rst_valid", dout_valid, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Impulse on channel 0, interleaved with the channel-1 isolation check
        send(0, 32'd1024, 32'd179, "imp0");
        send(1, 32'd1024, 32'd179, "iso1");
        send(0, 32'd0,    32'd296, "imp1");
        send(0, 32'd0,    32'd193, "imp2");
        send(1, 32'd0,    32'd296, "iso2");

        // Round-robin with both channels requesting continuously after reset
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset     = 1'b0;
        din       = '0;
        din_valid = 2'b11;
        both_hi   = 1'b0;
        for (int i = 0; i < 60 && g.size() < 4; i++) begin
            #1;
            if (din_ready == 2'b11) both_hi = 1'b1;
            else if (din_ready == 2'b01) g.push_back(0);
            else if (din_ready == 2'b10) g.push_back(1);
            @(negedge clock);
        end
        din_valid = 2'b00;
        chk("rr_count", g.size(), 4);
        for (int k = 0; k < g.size(); k++) chk("rr_grant", g[k], k % 2);
        chk("rr_both", both_hi, 1'b0);

        // Backpressure: hold OUT for 10 cycles while channel 1 waits
        reset = 1'b1;
        @(negedge clock);
        reset      = 1'b0;
        dout_ready = 1'b0;
        din[0]     = 32'd1024;
        din_valid  = 2'b01;
        #1;
        chk("bp_rdy0", din_ready, 2'b01);
        @(negedge clock);
        din[1]    = 32'd2048;
        din_valid = 2'b10;
        #1;
        chk("bp_busy_rdy", din_ready, 2'b00);
        lat = 1;
        while (dout_valid !== 1'b1 && lat < 12) begin
            @(negedge clock);
            lat++;
        end
        chk("bp_lat", lat, 4);
        chk("bp_dout", dout, 32'd179);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("bp_hold_valid", dout_valid, 1'b1);
            chk("bp_hold_dout", dout, 32'd179);
            chk("bp_hold_ch", dout_ch, 1'b0);
            chk("bp_hold_rdy", din_ready, 2'b00);
        end
        dout_ready = 1'b1;
        @(negedge clock);
        #1;
        chk("bp_reaccept", din_ready, 2'b10);
        @(negedge clock);
        din_valid = 2'b00;
        lat = 1;
        while (dout_valid !== 1'b1 && lat < 12) begin
            @(negedge clock);
            lat++;
        end
        chk("bp2_lat", lat, 4);
        chk("bp2_dout", dout, 32'd358);
        chk("bp2_ch", dout_ch, 1'b1);
        @(negedge clock);

        // Reset during MB1 discards the sample and clears the history
        din[0]    = 32'd1024;
        din_valid = 2'b01;
        @(negedge clock);
        din_valid = 2'b00;
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("mid_rdy", din_ready, 2'b00);
        chk("mid_dout", dout, 32'd0);
        chk("mid_ch", dout_ch, 1'b0);
        chk("mid_valid", dout_valid, 1'b0);
        @(negedge clock);
        chk("mid_valid2", dout_valid, 1'b0);
        reset = 1'b0;
        send(0, 32'd1024, 32'd179, "rst_hist");

`ifdef IIR_SCHED_COEF_WR_EN
        // Coefficient writes, plus a snapshot taken at accept
        coef_wr = 1'b1; coef_addr = 2'd0; coef_wdata = 32'd1024;
        @(negedge clock);
        coef_addr = 2'd1; coef_wdata = 32'd0;
        @(negedge clock);
        coef_addr = 2'd2; coef_wdata = 32'd0;
        @(negedge clock);
        coef_wr = 1'b0;
        send(0, 32'd5, 32'd5, "coef_new");
        din[0]    = 32'd5;
        din_valid = 2'b01;
        @(negedge clock);
        din_valid = 2'b00;
        coef_wr = 1'b1; coef_addr = 2'd0; coef_wdata = 32'd2048;
        @(negedge clock);
        coef_wr = 1'b0;
        lat = 2;
        while (dout_valid !== 1'b1 && lat < 12) begin
            @(negedge clock);
            lat++;
        end
        chk("coef_snap_lat", lat, 4);
        chk("coef_snap", dout, 32'd5);
        @(negedge clock);
        send(0, 32'd5, 32'd10, "coef_after");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
